vernam_decipher: RTL and testbench

- PicoBlaze (kcpsm3) port-mapped Vernam decryption peripheral. It is the receive end of the cipher/random-key processor pair.
- The host processor writes ciphertext bytes. The block XORs each byte with an internal 8-bit LFSR keystream, seeded identically to the sender's key generator, and queues the plaintext in a small FIFO.
- The host reads plaintext and status back through the same port_id/in_port bus.

---
 rtl/vernam_decipher.sv | 92 +++++++++
 tb/tb_vernam_decipher.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vernam_decipher.sv
// vernam_decipher: kcpsm3 port-mapped Vernam receiver, XORs ciphertext with an
// 8-bit Galois LFSR keystream and queues plaintext in a small FIFO.
module vernam_decipher #(
   parameter logic [7:0] BASE_ADDR  = 8'h80,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] LFSR_TAPS  = 8'hB8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       data_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic [7:0]    r_stage, r_key, r_in_port;
   logic          r_stage_valid, r_ovf;
   logic          w_hit, w_cipher, w_seed, w_ctrl, w_flush, w_clr;
   logic          w_empty, w_full, w_pop, w_push, w_drop;
   logic [1:0]    w_off;
   logic [7:0]    w_key_next, w_rd_data;

   assign w_hit      = port_id[7:2] == BASE_ADDR[7:2];
   assign w_off      = port_id[1:0];
   assign w_cipher   = write_strobe & w_hit & (w_off == 2'd0);
   assign w_seed     = write_strobe & w_hit & (w_off == 2'd1);
   assign w_ctrl     = write_strobe & w_hit & (w_off == 2'd2);
   assign w_flush    = w_ctrl & out_port[0];
   assign w_clr      = w_ctrl & out_port[1];
   assign w_empty    = r_cnt == '0;
   assign w_full     = r_cnt == (AW+1)'(FIFO_DEPTH);
   assign w_pop      = read_strobe & w_hit & (w_off == 2'd0) & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push     = r_stage_valid & (~w_full | w_pop);
   assign w_drop     = r_stage_valid & w_full & ~w_pop;
   assign w_key_next = {1'b0, r_key[7:1]} ^ (r_key[0] ? LFSR_TAPS : 8'h00);
   assign data_ready = ~w_empty;
   assign in_port    = r_in_port;

   always_comb begin
      w_rd_data = 8'h00;
      if (w_hit && w_off == 2'd0)
         w_rd_data = w_empty ? 8'h00 : r_fifo[r_rp];
      else if (w_hit && w_off == 2'd1)
         w_rd_data = {4'b0, r_ovf, r_stage_valid, w_full, w_empty};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wp          <= '0;
         r_rp          <= '0;
         r_cnt         <= '0;
         r_stage       <= 8'h00;
         r_stage_valid <= 1'b0;
         r_key         <= 8'h01;
         r_ovf         <= 1'b0;
         r_in_port     <= 8'h00;
      end else begin
         r_in_port     <= w_rd_data;
         r_stage_valid <= w_cipher;
         if (w_cipher)
            r_stage <= out_port;
         // Seed load overrides the keystream advance of a processing stage.
         if (w_seed)
            r_key <= (out_port == 8'h00) ? 8'h01 : out_port;
         else if (r_stage_valid)
            r_key <= w_key_next;
         r_ovf <= w_clr ? 1'b0 : (r_ovf | w_drop);
         if (w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_push)
               r_wp <= r_wp + 1'b1;
            if (w_pop)
               r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo[r_wp] <= r_stage ^ r_key;
   end
endmodule

// File: tb/tb_vernam_decipher.sv
// tb_vernam_decipher: randomized and directed checks of vernam_decipher against
// a queue-based keystream model.
module tb_vernam_decipher;
   localparam logic [7:0] BASE  = 8'h80;
   localparam int         DEPTH = 4;
   localparam logic [7:0] TAPS  = 8'hB8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] in_port;
   logic       data_ready;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_key;
   logic [7:0] m_q[$];
   logic       m_ovf;

   vernam_decipher #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .LFSR_TAPS(TAPS)) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe),
      .in_port(in_port), .data_ready(data_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] key_step(input logic [7:0] k);
      int v;
      v = int'(k) / 2;
      if (k % 2 == 1) v = v ^ int'(TAPS);
      return 8'(v);
   endfunction

   function automatic logic [7:0] m_status();
      return {4'b0, m_ovf, 1'b0, m_q.size() == DEPTH, m_q.size() == 0};
   endfunction

   task automatic m_reset();
      m_key = 8'h01;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] off, input logic [7:0] d);
      port_id = BASE | 8'(off);
      out_port = d;
      write_strobe = 1'b1;
      @(posedge clk);
      #1;
      write_strobe = 1'b0;
      port_id = 8'h00;
      if (off == 2'd0) begin
         if (m_q.size() == DEPTH) m_ovf = 1'b1;
         else m_q.push_back(d ^ m_key);
         m_key = key_step(m_key);
      end else if (off == 2'd1) begin
         m_key = (d == 8'h00) ? 8'h01 : d;
      end else if (off == 2'd2) begin
         if (d[0]) m_q.delete();
         if (d[1]) m_ovf = 1'b0;
      end
   endtask

   task automatic rd(input logic [1:0] off, output logic [7:0] v);
      logic [7:0] t;
      port_id = BASE | 8'(off);
      read_strobe = 1'b1;
      @(posedge clk);
      #1;
      v = in_port;
      read_strobe = 1'b0;
      port_id = 8'h00;
      if (off == 2'd0 && m_q.size() > 0) t = m_q.pop_front();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_reset();
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      checks++;
      if (in_port !== 8'h00) begin errors++; $display("FAIL reset_in_port got=%h exp=00", in_port); end
      checks++;
      if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
      rd(2'd1, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL reset_status got=%h exp=01", v); end
   endtask

   task automatic test_decrypt();
      logic [7:0] v;
      logic [7:0] exp[3] = '{8'h48, 8'h19, 8'hAE};
      wr(2'd1, 8'h5A);
      wr(2'd0, 8'h12);
      wr(2'd0, 8'h34);
      wr(2'd0, 8'h00);
      idle(1);
      checks++;
      if (data_ready !== 1'b1) begin errors++; $display("FAIL decrypt_ready got=%b exp=1", data_ready); end
      for (int i = 0; i < 3; i++) begin
         rd(2'd0, v);
         checks++;
         if (v !== exp[i]) begin errors++; $display("FAIL decrypt_plain%0d got=%h exp=%h", i, v, exp[i]); end
      end
   endtask

   task automatic test_seed_zero();
      logic [7:0] v;
      wr(2'd1, 8'h00);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
      idle(1);
      rd(2'd0, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL seed0_plain0 got=%h exp=01", v); end
      rd(2'd0, v);
      checks++;
      if (v !== 8'hB8) begin errors++; $display("FAIL seed0_plain1 got=%h exp=B8", v); end
      rd(2'd1, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL seed0_status got=%h exp=01", v); end
      rd(2'd0, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL empty_read got=%h exp=00", v); end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      logic [7:0] exp[4] = '{8'h5A, 8'h2D, 8'hAE, 8'h57};
      wr(2'd1, 8'h5A);
      repeat (5) wr(2'd0, 8'h00);
      idle(1);
      rd(2'd1, v);
      checks++;
      if (v !== 8'h0A) begin errors++; $display("FAIL ovf_status got=%h exp=0A", v); end
      for (int i = 0; i < 4; i++) begin
         rd(2'd0, v);
         checks++;
         if (v !== exp[i]) begin errors++; $display("FAIL ovf_plain%0d got=%h exp=%h", i, v, exp[i]); end
      end
      wr(2'd0, 8'h00);
      idle(1);
      rd(2'd0, v);
      checks++;
      if (v !== 8'hF1) begin errors++; $display("FAIL ovf_key5 got=%h exp=F1", v); end
   endtask

   task automatic test_flush();
      logic [7:0] v;
      wr(2'd0, 8'h33);
      wr(2'd0, 8'h44);
      idle(1);
      wr(2'd2, 8'h03);
      rd(2'd1, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL flush_status got=%h exp=01", v); end
      checks++;
      if (data_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", data_ready); end
   endtask

   task automatic test_seed_collision();
      logic [7:0] v, e;
      wr(2'd1, 8'hC3);
      wr(2'd0, 8'h77);
      wr(2'd1, 8'h29);
      wr(2'd0, 8'h10);
      idle(1);
      for (int i = 0; i < 2; i++) begin
         e = m_q[0];
         rd(2'd0, v);
         checks++;
         if (v !== e) begin errors++; $display("FAIL seedcol_plain%0d got=%h exp=%h", i, v, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      wr(2'd1, 8'h5A);
      wr(2'd0, 8'hA1);
      wr(2'd0, 8'hB2);
      do_reset();
      rd(2'd1, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL b2b_reset_status got=%h exp=01", v); end
      checks++;
      if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_reset_ready got=%b exp=0", data_ready); end
      wr(2'd0, 8'hFF);
      idle(1);
      rd(2'd0, v);
      checks++;
      if (v !== 8'hFE) begin errors++; $display("FAIL b2b_key_reset got=%h exp=FE", v); end
   endtask

   task automatic test_random();
      logic [7:0] v, e;
      int op;
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         if (op < 4) begin
            wr(2'd0, 8'($urandom));
            idle(1);
         end else if (op == 4) begin
            wr(2'd1, 8'($urandom));
            idle(1);
         end else if (op == 5) begin
            wr(2'd2, 8'($urandom_range(0, 3)));
            idle(1);
         end else if (op < 9) begin
            e = (m_q.size() > 0) ? m_q[0] : 8'h00;
            rd(2'd0, v);
            checks++;
            if (v !== e) begin errors++; $display("FAIL rand_plain it=%0d got=%h exp=%h", i, v, e); end
         end else begin
            e = m_status();
            rd(2'd1, v);
            checks++;
            if (v !== e) begin errors++; $display("FAIL rand_status it=%0d got=%h exp=%h", i, v, e); end
            checks++;
            if (data_ready !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_ready it=%0d got=%b exp=%b", i, data_ready, m_q.size() > 0); end
         end
      end
   endtask

   initial begin
      m_reset();
      idle(2);
      test_reset();
      test_decrypt();
      test_seed_zero();
      test_overflow();
      test_flush();
      test_seed_collision();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
